// File: rtl/bios_loader.sv
// Download front end for the BIOS and XTIDE option-ROM RAM write ports.
// Define BIOS_LOADER_CHKSUM_EN to add the chksum/chksum_ok outputs.
module bios_loader #(
    parameter logic [16:0] BIOS_BASE  = 17'h00000,
    parameter logic [13:0] XTIDE_BASE = 14'h0000
) (
    input  logic        clka,
    input  logic        rst_n,
    input  logic        dl_active,
    input  logic        dl_index,
    input  logic        dl_valid,
    input  logic [7:0]  dl_data,
    output logic        dl_ready,
    output logic        bios_ena,
    output logic        bios_wea,
    output logic [16:0] bios_addra,
    output logic [7:0]  bios_dina,
    output logic        xtide_ena,
    output logic        xtide_wea,
    output logic [13:0] xtide_addra,
    output logic [7:0]  xtide_dina,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        overflow,
    output logic [17:0] byte_count
`ifdef BIOS_LOADER_CHKSUM_EN
    ,
    output logic [7:0]  chksum,
    output logic        chksum_ok
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t      state_q, state_d;
    logic        tgt_q, tgt_d;
    logic        full_q, full_d;
    logic [16:0] baddr_q, baddr_d;
    logic [13:0] xaddr_q, xaddr_d;
    logic        dl_ready_q, dl_ready_d;
    logic        bios_en_q, bios_en_d;
    logic [16:0] bios_addra_q, bios_addra_d;
    logic [7:0]  bios_dina_q, bios_dina_d;
    logic        xtide_en_q, xtide_en_d;
    logic [13:0] xtide_addra_q, xtide_addra_d;
    logic [7:0]  xtide_dina_q, xtide_dina_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        load_done_q, load_done_d;
    logic        overflow_q, overflow_d;
    logic [17:0] byte_count_q, byte_count_d;
    logic        accept;
`ifdef BIOS_LOADER_CHKSUM_EN
    logic [7:0]  chksum_q, chksum_d;
    logic        chksum_ok_q, chksum_ok_d;
`endif

    assign accept = (state_q == LOAD) && dl_valid && dl_ready_q;

    always_comb begin
        state_d       = state_q;
        tgt_d         = tgt_q;
        full_d        = full_q;
        baddr_d       = baddr_q;
        xaddr_d       = xaddr_q;
        dl_ready_d    = dl_ready_q;
        bios_en_d     = 1'b0;
        bios_addra_d  = bios_addra_q;
        bios_dina_d   = bios_dina_q;
        xtide_en_d    = 1'b0;
        xtide_addra_d = xtide_addra_q;
        xtide_dina_d  = xtide_dina_q;
        cpu_hold_d    = cpu_hold_q;
        load_done_d   = 1'b0;
        overflow_d    = overflow_q;
        byte_count_d  = byte_count_q;
`ifdef BIOS_LOADER_CHKSUM_EN
        chksum_d      = chksum_q;
        chksum_ok_d   = chksum_ok_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (dl_active) begin
                    state_d      = LOAD;
                    tgt_d        = dl_index;
                    full_d       = 1'b0;
                    baddr_d      = BIOS_BASE;
                    xaddr_d      = XTIDE_BASE;
                    dl_ready_d   = 1'b1;
                    cpu_hold_d   = 1'b1;
                    overflow_d   = 1'b0;
                    byte_count_d = '0;
`ifdef BIOS_LOADER_CHKSUM_EN
                    chksum_d     = '0;
                    chksum_ok_d  = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (accept) begin
                    if (byte_count_q != 18'h3FFFF)
                        byte_count_d = byte_count_q + 18'd1;
                    // Past the last location: count the byte but drop it.
                    if (full_q) begin
                        overflow_d = 1'b1;
                    end else begin
`ifdef BIOS_LOADER_CHKSUM_EN
                        chksum_d = chksum_q + dl_data;
`endif
                        if (tgt_q) begin
                            xtide_en_d    = 1'b1;
                            xtide_addra_d = xaddr_q;
                            xtide_dina_d  = dl_data;
                            if (xaddr_q == 14'h3FFF) full_d = 1'b1;
                            else xaddr_d = xaddr_q + 14'd1;
                        end else begin
                            bios_en_d    = 1'b1;
                            bios_addra_d = baddr_q;
                            bios_dina_d  = dl_data;
                            if (baddr_q == 17'h1FFFF) full_d = 1'b1;
                            else baddr_d = baddr_q + 17'd1;
                        end
                    end
                end
                if (!dl_active) begin
                    state_d    = FLUSH;
                    dl_ready_d = 1'b0;
                end
            end
            FLUSH: begin
                state_d     = DONE;
                load_done_d = 1'b1;
`ifdef BIOS_LOADER_CHKSUM_EN
                chksum_ok_d = (chksum_q == 8'h00);
`endif
            end
            DONE: begin
                state_d    = IDLE;
                cpu_hold_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tgt_q         <= 1'b0;
            full_q        <= 1'b0;
            baddr_q       <= BIOS_BASE;
            xaddr_q       <= XTIDE_BASE;
            dl_ready_q    <= 1'b0;
            bios_en_q     <= 1'b0;
            bios_addra_q  <= '0;
            bios_dina_q   <= '0;
            xtide_en_q    <= 1'b0;
            xtide_addra_q <= '0;
            xtide_dina_q  <= '0;
            cpu_hold_q    <= 1'b0;
            load_done_q   <= 1'b0;
            overflow_q    <= 1'b0;
            byte_count_q  <= '0;
`ifdef BIOS_LOADER_CHKSUM_EN
            chksum_q      <= '0;
            chksum_ok_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            tgt_q         <= tgt_d;
            full_q        <= full_d;
            baddr_q       <= baddr_d;
            xaddr_q       <= xaddr_d;
            dl_ready_q    <= dl_ready_d;
            bios_en_q     <= bios_en_d;
            bios_addra_q  <= bios_addra_d;
            bios_dina_q   <= bios_dina_d;
            xtide_en_q    <= xtide_en_d;
            xtide_addra_q <= xtide_addra_d;
            xtide_dina_q  <= xtide_dina_d;
            cpu_hold_q    <= cpu_hold_d;
            load_done_q   <= load_done_d;
            overflow_q    <= overflow_d;
            byte_count_q  <= byte_count_d;
`ifdef BIOS_LOADER_CHKSUM_EN
            chksum_q      <= chksum_d;
            chksum_ok_q   <= chksum_ok_d;
`endif
        end
    end

    assign dl_ready    = dl_ready_q;
    assign bios_ena    = bios_en_q;
    assign bios_wea    = bios_en_q;
    assign bios_addra  = bios_addra_q;
    assign bios_dina   = bios_dina_q;
    assign xtide_ena   = xtide_en_q;
    assign xtide_wea   = xtide_en_q;
    assign xtide_addra = xtide_addra_q;
    assign xtide_dina  = xtide_dina_q;
    assign cpu_hold    = cpu_hold_q;
    assign load_done   = load_done_q;
    assign overflow    = overflow_q;
    assign byte_count  = byte_count_q;
`ifdef BIOS_LOADER_CHKSUM_EN
    assign chksum      = chksum_q;
    assign chksum_ok   = chksum_ok_q;
`endif

endmodule

// File: tb/tb_bios_loader.sv
// Directed bench for bios_loader: default instance plus one whose
// XTIDE_BASE sits two bytes below the end of the XTIDE RAM.
module tb_bios_loader;

    logic clka = 1'b0;
    logic rst_n = 1'b0;
    logic dl_active = 1'b0;
    logic dl_index = 1'b0;
    logic dl_valid = 1'b0;
    logic [7:0] dl_data = '0;

    logic        dl_ready, bios_ena, bios_wea, xtide_ena, xtide_wea;
    logic [16:0] bios_addra;
    logic [7:0]  bios_dina, xtide_dina;
    logic [13:0] xtide_addra;
    logic        cpu_hold, load_done, overflow;
    logic [17:0] byte_count;

    logic        dl_ready2, bios_ena2, bios_wea2, xtide_ena2, xtide_wea2;
    logic [16:0] bios_addra2;
    logic [7:0]  bios_dina2, xtide_dina2;
    logic [13:0] xtide_addra2;
    logic        cpu_hold2, load_done2, overflow2;
    logic [17:0] byte_count2;
`ifdef BIOS_LOADER_CHKSUM_EN
    logic [7:0] chksum, chksum2;
    logic       chksum_ok, chksum_ok2;
`endif

    int total = 0;
    int bad = 0;

    always #5 clka = ~clka;

    bios_loader dut (
        .clka(clka), .rst_n(rst_n), .dl_active(dl_active),
        .dl_index(dl_index), .dl_valid(dl_valid), .dl_data(dl_data),
        .dl_ready(dl_ready), .bios_ena(bios_ena), .bios_wea(bios_wea),
        .bios_addra(bios_addra), .bios_dina(bios_dina),
        .xtide_ena(xtide_ena), .xtide_wea(xtide_wea),
        .xtide_addra(xtide_addra), .xtide_dina(xtide_dina),
        .cpu_hold(cpu_hold), .load_done(load_done), .overflow(overflow),
        .byte_count(byte_count)
`ifdef BIOS_LOADER_CHKSUM_EN
        , .chksum(chksum), .chksum_ok(chksum_ok)
`endif
    );

    bios_loader #(.BIOS_BASE(17'h00000), .XTIDE_BASE(14'h3FFE)) dut2 (
        .clka(clka), .rst_n(rst_n), .dl_active(dl_active),
        .dl_index(dl_index), .dl_valid(dl_valid), .dl_data(dl_data),
        .dl_ready(dl_ready2), .bios_ena(bios_ena2), .bios_wea(bios_wea2),
        .bios_addra(bios_addra2), .bios_dina(bios_dina2),
        .xtide_ena(xtide_ena2), .xtide_wea(xtide_wea2),
        .xtide_addra(xtide_addra2), .xtide_dina(xtide_dina2),
        .cpu_hold(cpu_hold2), .load_done(load_done2), .overflow(overflow2),
        .byte_count(byte_count2)
`ifdef BIOS_LOADER_CHKSUM_EN
        , .chksum(chksum2), .chksum_ok(chksum_ok2)
`endif
    );

    // Write monitor, sampled on the falling edge.
    int cyc = 0;
    int ld_cnt = 0;
    int ew_err = 0;
    logic [16:0] b_addr[$];
    logic [7:0]  b_data[$];
    int          b_cyc[$];
    logic [13:0] x_addr[$];
    logic [7:0]  x_data[$];
    logic [13:0] x2_addr[$];
    logic [7:0]  x2_data[$];

    always @(posedge clka) cyc <= cyc + 1;

    always @(negedge clka) begin
        if (bios_ena !== bios_wea || xtide_ena !== xtide_wea) ew_err++;
        if (bios_ena && xtide_ena) ew_err++;
        if (load_done) ld_cnt++;
        if (bios_ena) begin
            b_addr.push_back(bios_addra);
            b_data.push_back(bios_dina);
            b_cyc.push_back(cyc);
        end
        if (xtide_ena) begin
            x_addr.push_back(xtide_addra);
            x_data.push_back(xtide_dina);
        end
        if (xtide_ena2) begin
            x2_addr.push_back(xtide_addra2);
            x2_data.push_back(xtide_dina2);
        end
    end

    logic [7:0] tx_q[$];
    int         gap_q[$];

    task automatic clear_logs();
        b_addr.delete(); b_data.delete(); b_cyc.delete();
        x_addr.delete(); x_data.delete();
        x2_addr.delete(); x2_data.delete();
    endtask

    task automatic do_load(input logic idx, input bit drop_last,
                           input int flip_at,
                           output bit done_seen, output bit hold_ok);
        int w;
        @(negedge clka);
        dl_index = idx;
        dl_active = 1'b1;
        hold_ok = 1'b1;
        @(negedge clka);
        for (int i = 0; i < tx_q.size(); i++) begin
            int g;
            g = (i < gap_q.size()) ? gap_q[i] : 0;
            if (i == flip_at) dl_index = ~dl_index;
            for (int k = 0; k < g; k++) begin
                dl_valid = 1'b0;
                @(negedge clka);
                if (!cpu_hold) hold_ok = 1'b0;
            end
            dl_valid = 1'b1;
            dl_data = tx_q[i];
            if (drop_last && i == tx_q.size() - 1) dl_active = 1'b0;
            w = 0;
            while (!dl_ready && w < 50) begin
                @(negedge clka);
                w++;
            end
            @(negedge clka);
            if (!cpu_hold) hold_ok = 1'b0;
        end
        dl_valid = 1'b0;
        dl_active = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (load_done) begin
                done_seen = 1'b1;
                break;
            end
            @(negedge clka);
        end
        repeat (3) @(negedge clka);
    endtask

    task automatic test_reset();
        @(negedge clka);
        total++;
        if ({dl_ready, bios_ena, bios_wea, bios_addra, bios_dina,
             xtide_ena, xtide_wea, xtide_addra, xtide_dina,
             cpu_hold, load_done, overflow, byte_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got nonzero ready=%b hold=%b cnt=%0h",
                     dl_ready, cpu_hold, byte_count);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clka);
        total++;
        if (dl_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet: ready=%b hold=%b want 0 0",
                     dl_ready, cpu_hold);
        end
    endtask

    task automatic test_bios_load();
        bit done, hold;
        int l0, errs;
        clear_logs();
        tx_q.delete(); gap_q.delete();
        for (int i = 0; i < 256; i++) tx_q.push_back(8'(i));
        l0 = ld_cnt;
        do_load(1'b0, 1'b0, -1, done, hold);
        total++;
        if (!done) begin
            bad++;
            $display("FAIL bios_done_seen: got 0 want 1");
        end
        total++;
        if (b_addr.size() != 256 || x_addr.size() != 0) begin
            bad++;
            $display("FAIL bios_write_count: got %0d/%0d want 256/0",
                     b_addr.size(), x_addr.size());
        end
        errs = 0;
        for (int i = 0; i < b_addr.size() && i < 256; i++)
            if (b_addr[i] !== 17'(i) || b_data[i] !== 8'(i) ||
                b_cyc[i] != b_cyc[0] + i) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL bios_write_seq: got %0d bad writes want 0", errs);
        end
        total++;
        if (byte_count !== 18'd256) begin
            bad++;
            $display("FAIL bios_byte_count: got %0d want 256", byte_count);
        end
        total++;
        if (ld_cnt - l0 != 1) begin
            bad++;
            $display("FAIL bios_done_pulse: got %0d want 1", ld_cnt - l0);
        end
        total++;
        if (!hold || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL bios_cpu_hold: during=%b after=%b want 1 0",
                     hold, cpu_hold);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL bios_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_xtide_load();
        bit done, hold;
        clear_logs();
        tx_q = '{8'hA5, 8'h5A, 8'hC3};
        gap_q.delete();
        do_load(1'b1, 1'b1, -1, done, hold);
        total++;
        if (!done || b_addr.size() != 0 || x_addr.size() != 3) begin
            bad++;
            $display("FAIL xtide_counts: done=%b bios=%0d xtide=%0d want 1 0 3",
                     done, b_addr.size(), x_addr.size());
        end
        total++;
        if (x_addr.size() == 3 &&
            (x_addr[0] !== 14'h0 || x_data[0] !== 8'hA5 ||
             x_addr[1] !== 14'h1 || x_data[1] !== 8'h5A ||
             x_addr[2] !== 14'h2 || x_data[2] !== 8'hC3)) begin
            bad++;
            $display("FAIL xtide_writes: last got %0h=%0h want 2=c3",
                     x_addr[2], x_data[2]);
        end
        total++;
        if (byte_count !== 18'd3) begin
            bad++;
            $display("FAIL xtide_byte_count: got %0d want 3", byte_count);
        end
    endtask

    task automatic test_overflow();
        bit done, hold;
        clear_logs();
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        gap_q.delete();
        do_load(1'b1, 1'b0, -1, done, hold);
        total++;
        if (x2_addr.size() != 2) begin
            bad++;
            $display("FAIL ovf_write_count: got %0d want 2", x2_addr.size());
        end else begin
            total++;
            if (x2_addr[0] !== 14'h3FFE || x2_data[0] !== 8'h11 ||
                x2_addr[1] !== 14'h3FFF || x2_data[1] !== 8'h22) begin
                bad++;
                $display("FAIL ovf_writes: got %0h/%0h want 3ffe/3fff",
                         x2_addr[0], x2_addr[1]);
            end
        end
        total++;
        if (overflow2 !== 1'b1 || byte_count2 !== 18'd4) begin
            bad++;
            $display("FAIL ovf_flags: ovf=%b cnt=%0d want 1 4",
                     overflow2, byte_count2);
        end
        total++;
        if (overflow !== 1'b0 || x_addr.size() != 4) begin
            bad++;
            $display("FAIL ovf_nonfull: ovf=%b writes=%0d want 0 4",
                     overflow, x_addr.size());
        end
    endtask

    task automatic test_gaps();
        bit done, hold;
        int errs;
        clear_logs();
        tx_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        gap_q = '{0, 2, 1, 0, 3, 0, 1, 2};
        do_load(1'b0, 1'b0, 3, done, hold);
        total++;
        if (b_addr.size() != 8 || x_addr.size() != 0) begin
            bad++;
            $display("FAIL gap_counts: bios=%0d xtide=%0d want 8 0",
                     b_addr.size(), x_addr.size());
        end
        errs = 0;
        for (int i = 0; i < b_addr.size() && i < 8; i++)
            if (b_addr[i] !== 17'(i) || b_data[i] !== 8'(8'h10 + i)) errs++;
        total++;
        if (errs != 0 || byte_count !== 18'd8 || !hold) begin
            bad++;
            $display("FAIL gap_writes: errs=%0d cnt=%0d hold=%b want 0 8 1",
                     errs, byte_count, hold);
        end
    endtask

    task automatic test_empty();
        bit done, hold;
        clear_logs();
        tx_q.delete(); gap_q.delete();
        do_load(1'b0, 1'b0, -1, done, hold);
        total++;
        if (!done || byte_count !== 18'd0 ||
            b_addr.size() != 0 || x_addr.size() != 0) begin
            bad++;
            $display("FAIL empty_load: done=%b cnt=%0d writes=%0d want 1 0 0",
                     done, byte_count, b_addr.size() + x_addr.size());
        end
    endtask

    task automatic test_reset_midload();
        bit done, hold;
        clear_logs();
        @(negedge clka);
        dl_index = 1'b0;
        dl_active = 1'b1;
        @(negedge clka);
        for (int i = 0; i < 10; i++) begin
            dl_valid = 1'b1;
            dl_data = 8'(8'h80 + i);
            @(negedge clka);
        end
        rst_n = 1'b0;
        dl_valid = 1'b0;
        dl_active = 1'b0;
        #1;
        total++;
        if ({dl_ready, bios_ena, bios_addra, bios_dina, cpu_hold,
             load_done, overflow, byte_count} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: hold=%b cnt=%0d want 0 0",
                     cpu_hold, byte_count);
        end
        total++;
        if (b_addr.size() != 10) begin
            bad++;
            $display("FAIL midreset_writes: got %0d want 10", b_addr.size());
        end
        @(negedge clka);
        rst_n = 1'b1;
        clear_logs();
        tx_q = '{8'hE1, 8'hE2};
        gap_q.delete();
        do_load(1'b0, 1'b0, -1, done, hold);
        total++;
        if (b_addr.size() != 2 || b_addr[0] !== 17'h0 ||
            b_addr[1] !== 17'h1 || b_data[1] !== 8'hE2) begin
            bad++;
            $display("FAIL midreset_restart: writes=%0d want 2 at base",
                     b_addr.size());
        end
    endtask

`ifdef BIOS_LOADER_CHKSUM_EN
    task automatic test_chksum();
        bit done, hold;
        tx_q = '{8'h01, 8'h02, 8'hFD};
        gap_q.delete();
        do_load(1'b0, 1'b0, -1, done, hold);
        total++;
        if (chksum !== 8'h00 || chksum_ok !== 1'b1) begin
            bad++;
            $display("FAIL chksum_zero: got %0h/%b want 00/1",
                     chksum, chksum_ok);
        end
        tx_q = '{8'h01, 8'h02};
        do_load(1'b0, 1'b0, -1, done, hold);
        total++;
        if (chksum !== 8'h03 || chksum_ok !== 1'b0) begin
            bad++;
            $display("FAIL chksum_nonzero: got %0h/%b want 03/0",
                     chksum, chksum_ok);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bios_load();
        test_xtide_load();
        test_overflow();
        test_gaps();
        test_empty();
        test_reset_midload();
`ifdef BIOS_LOADER_CHKSUM_EN
        test_chksum();
`endif
        total++;
        if (ew_err != 0) begin
            bad++;
            $display("FAIL ena_wea_pairing: got %0d violations want 0", ew_err);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
